// File: rtl/rtttl_tone_gen.sv
// Square-wave tone generator for RTTTL {octave, note} codes; pitch changes land only on half-period boundaries.
// Optional articulation gap between differing notes is built when RTTTL_TONE_GAP_EN is defined.
module rtttl_tone_gen #(
    parameter int unsigned CLK_HZ     = 1_000_000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] octave,
    input  logic [3:0] note,
    output logic       tone_out,
    output logic       active
);

    // Rounded half-period in clocks for an octave-4 frequency given in centihertz.
    function automatic logic [31:0] base_half(input int unsigned f_chz);
        logic [63:0] num;
        num = 64'(CLK_HZ) * 64'd100 + 64'(f_chz);
        return 32'(num / (64'd2 * 64'(f_chz)));
    endfunction

    // Indexed directly by the note code; rest codes map to a harmless value of 1.
    localparam logic [31:0] BASE [16] = '{
        32'd1,
        base_half(26163), base_half(27718), base_half(29366), base_half(31113),
        base_half(32963), base_half(34923), base_half(36999), base_half(39200),
        base_half(41530), base_half(44000), base_half(46616), base_half(49388),
        32'd1, 32'd1, 32'd1
    };

    typedef enum logic [1:0] {
        S_REST,
        S_TONE,
        S_GAP
    } state_t;

    state_t           state_q;
    logic             tone_q;
    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       oct_q;
    logic [3:0]       note_q;

    logic             code_rest;
    logic [31:0]      scaled;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] reload;

    assign code_rest = (note_q == 4'd0) || (note_q > 4'd12) || oct_q[3];

    always_comb begin
        if (!oct_q[2]) begin
            scaled = BASE[note_q] << (3'd4 - {1'b0, oct_q[1:0]});
        end else begin
            scaled = BASE[note_q] >> oct_q[1:0];
        end
        half = scaled[CNT_W-1:0];
        if (half == '0) begin
            half = CNT_W'(1);
        end
        reload = half - CNT_W'(1);
    end

`ifdef RTTTL_TONE_GAP_EN
    localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);

    // Code currently sounding, used to spot a note change at a boundary.
    logic [7:0] cur_q;
`else
    logic unused_gap_cycles;
    assign unused_gap_cycles = ^GAP_CYCLES;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_REST;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
            oct_q    <= 4'd0;
            note_q   <= 4'd0;
`ifdef RTTTL_TONE_GAP_EN
            cur_q    <= 8'd0;
`endif
        end else begin
            oct_q  <= octave;
            note_q <= note;
            case (state_q)
                S_REST: begin
                    if (!code_rest) begin
                        state_q  <= S_TONE;
                        tone_q   <= 1'b1;
                        active_q <= 1'b1;
                        cnt_q    <= reload;
`ifdef RTTTL_TONE_GAP_EN
                        cur_q    <= {oct_q, note_q};
`endif
                    end
                end
                S_TONE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (code_rest) begin
                        state_q  <= S_REST;
                        tone_q   <= 1'b0;
                        active_q <= 1'b0;
                        cnt_q    <= '0;
`ifdef RTTTL_TONE_GAP_EN
                    end else if ({oct_q, note_q} != cur_q) begin
                        state_q <= S_GAP;
                        tone_q  <= 1'b0;
                        cnt_q   <= GAP_RELOAD;
                        cur_q   <= {oct_q, note_q};
`endif
                    end else begin
                        tone_q <= ~tone_q;
                        cnt_q  <= reload;
                    end
                end
`ifdef RTTTL_TONE_GAP_EN
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (code_rest) begin
                        state_q  <= S_REST;
                        tone_q   <= 1'b0;
                        active_q <= 1'b0;
                    end else begin
                        state_q <= S_TONE;
                        tone_q  <= 1'b1;
                        cnt_q   <= reload;
                        cur_q   <= {oct_q, note_q};
                    end
                end
`endif
                default: begin
                    state_q  <= S_REST;
                    tone_q   <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign tone_out = tone_q;
    assign active   = active_q;

endmodule

// File: tb/tb_rtttl_tone_gen.sv
// Scoreboard bench for rtttl_tone_gen: expected output transitions (cycle, level) are queued by the stimulus
// and matched by a monitor that watches {tone_out, active} for changes.
module tb_rtttl_tone_gen;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] octave = 4'd0;
    logic [3:0] note = 4'd0;
    logic       tone_out;
    logic       active;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int         cyc;
        logic [1:0] lvl;
    } ev_t;

    ev_t exp_q[$];

    rtttl_tone_gen dut (
        .clk     (clk),
        .rstn    (rstn),
        .octave  (octave),
        .note    (note),
        .tone_out(tone_out),
        .active  (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic expect_ev(input int c, input logic t, input logic a);
        ev_t e;
        e.cyc = c;
        e.lvl = {t, a};
        exp_q.push_back(e);
    endtask

    task automatic set_code(input logic [3:0] o, input logic [3:0] n);
        octave = o;
        note   = n;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of {tone_out, active} must match the head of the queue.
    initial begin
        logic [1:0] prev;
        ev_t        e;
        prev = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if ({tone_out, active} != prev) begin
                prev = {tone_out, active};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_edge: level %b at cycle %0d, expected no change", prev, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_cycle", cyc, e.cyc);
                    chk("edge_level", int'(prev), int'(e.lvl));
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tone", int'(tone_out), 0);
        chk("reset_active", int'(active), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // A4: halves of 1136, a short glitch to D4 mid-half, then rest inside a high half.
        t = cyc;
        set_code(4'd4, 4'd10);
        expect_ev(t + 2,    1'b1, 1'b1);
        expect_ev(t + 1138, 1'b0, 1'b1);
        expect_ev(t + 2274, 1'b1, 1'b1);
        expect_ev(t + 3410, 1'b0, 1'b1);
        expect_ev(t + 4546, 1'b1, 1'b1);
        expect_ev(t + 5682, 1'b0, 1'b1);
        expect_ev(t + 6818, 1'b1, 1'b1);
        expect_ev(t + 7954, 1'b0, 1'b0);
        wait_until(t + 4546 + 400);
        set_code(4'd4, 4'd3);
        repeat (10) @(negedge clk);
        set_code(4'd4, 4'd10);
        wait_until(t + 6818 + 300);
        set_code(4'd4, 4'd0);
        wait_until(t + 7954 + 20);
        chk("a4_rest_tone", int'(tone_out), 0);
        chk("a4_rest_active", int'(active), 0);

        // Invalid codes from REST stay silent.
        set_code(4'd4, 4'd13);
        repeat (40) @(negedge clk);
        set_code(4'd9, 4'd5);
        repeat (40) @(negedge clk);
        chk("invalid_tone", int'(tone_out), 0);
        chk("invalid_active", int'(active), 0);

`ifdef RTTTL_TONE_GAP_EN
        // A4 -> B4 with a 2000-clock articulation gap.
        t = cyc;
        set_code(4'd4, 4'd10);
        expect_ev(t + 2,    1'b1, 1'b1);
        expect_ev(t + 1138, 1'b0, 1'b1);
        expect_ev(t + 3138, 1'b1, 1'b1);
        expect_ev(t + 4150, 1'b0, 1'b1);
        expect_ev(t + 5162, 1'b0, 1'b0);
        wait_until(t + 100);
        set_code(4'd4, 4'd12);
        wait_until(t + 4150 + 50);
        set_code(4'd0, 4'd0);
        wait_until(t + 5162 + 20);
`else
        // C4 (1911), octave 0 (30576) after the running half, then octave 7 (238).
        t = cyc;
        set_code(4'd4, 4'd1);
        expect_ev(t + 2,     1'b1, 1'b1);
        expect_ev(t + 1913,  1'b0, 1'b1);
        expect_ev(t + 32489, 1'b1, 1'b1);
        expect_ev(t + 63065, 1'b0, 1'b1);
        expect_ev(t + 63303, 1'b1, 1'b1);
        expect_ev(t + 63541, 1'b0, 1'b1);
        expect_ev(t + 63779, 1'b0, 1'b0);
        wait_until(t + 100);
        set_code(4'd0, 4'd1);
        wait_until(t + 32489 + 100);
        set_code(4'd7, 4'd1);
        wait_until(t + 63541 + 50);
        set_code(4'd0, 4'd0);
        wait_until(t + 63779 + 20);
`endif

        // A5 (568): reset mid-high half silences immediately.
        t = cyc;
        set_code(4'd5, 4'd10);
        expect_ev(t + 2,    1'b1, 1'b1);
        expect_ev(t + 570,  1'b0, 1'b1);
        expect_ev(t + 1138, 1'b1, 1'b1);
        expect_ev(t + 1339, 1'b0, 1'b0);
        wait_until(t + 1138 + 200);
        #2;
        rstn = 1'b0;
        set_code(4'd0, 4'd0);
        #1;
        chk("async_reset_tone", int'(tone_out), 0);
        chk("async_reset_active", int'(active), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_tone", int'(tone_out), 0);
        chk("post_reset_active", int'(active), 0);

        // Restart A5 after reset, then rest inside the low half.
        t = cyc;
        set_code(4'd5, 4'd10);
        expect_ev(t + 2,    1'b1, 1'b1);
        expect_ev(t + 570,  1'b0, 1'b1);
        expect_ev(t + 1138, 1'b0, 1'b0);
        wait_until(t + 570 + 100);
        set_code(4'd0, 4'd0);
        wait_until(t + 1138 + 20);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtttl_tone_gen.md
Name: rtttl_tone_gen

Overview:
- Consumer end of the rtttl_sequencer output interface.
- Takes the sequencer's {octave, note} code and synthesises a 50%-duty square wave on one pin for a speaker or piezo.
- Pitch is derived from an elaboration-time octave-4 half-period table, scaled by octave shift.
- Pitch changes are glitch-free: they apply only at half-period boundaries.

Parameters:
- CLK_HZ, 1_000_000, input clock frequency in Hz; used only to build the half-period table at elaboration.
- CNT_W, 16, half-period counter width; must hold the octave-0 C half-period.
- GAP_CYCLES, 2000, articulation silence length in clocks (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- octave  input  4  octave code from the sequencer; 0..7 valid, 8..15 treated as rest
- note  input  4  note code: 0 = rest, 1..12 = C, C#, D, D#, E, F, F#, G, G#, A, A#, B; 13..15 = rest
- tone_out  output  1  square-wave audio output
- active  output  1  high while the generator is in TONE state

Behaviour:
- Reset:
  - One clock; async active-low reset.
  - State = REST; tone_out = 0, active = 0, counter = 0, pending/current code registers = rest.
- Input sampling: {octave, note} registered every clk; a code is "rest" if note = 0, note > 12, or octave > 7.
- Half-period table:
  - BASE[n] = round(CLK_HZ*100 / (2*F4c[n])), where F4c are octave-4 frequencies in centihertz (C4 = 26163 ... B4 = 49388).
  - HALF = BASE << (4-octave) for octave < 4; BASE >> (octave-4) for octave >= 4; right shifts truncate.
  - Counter reload value = HALF-1.
- States:
  - REST:
    - tone_out = 0, active = 0.
    - A non-rest code sampled at edge k moves to TONE at edge k+1: tone_out = 1, active = 1, counter = HALF-1.
  - TONE:
    - counter decrements each clk.
    - At an edge with counter = 0 and a non-rest current code: tone_out toggles and the counter reloads with HALF-1 of the most recently sampled code, so pending pitch changes take effect here only.
    - At an edge with counter = 0 and the sampled code = rest: go to REST; tone_out = 0; active = 0.
- Each output level therefore lasts exactly HALF clocks. Full period = 2*HALF. Pitch changes never truncate a half-cycle.
- Same code held continuously: uninterrupted tone; no re-trigger.
- Input changes mid-half-period: only the value present at the boundary edge matters. Intermediate codes are ignored.
- rstn asserted mid-tone: immediate silence (tone_out = 0) regardless of phase.
- HALF = 0 is unreachable with the default parameters. If CLK_HZ is too low, HALF is clamped to 1.

Optional Feature:
- Macro: RTTTL_TONE_GAP_EN.
- When defined:
  - Adds a GAP state.
  - A change from one non-rest code to a different non-rest code, detected at a half-period boundary, enters GAP: tone_out = 0, active = 1, for GAP_CYCLES clocks.
  - After GAP, TONE restarts with tone_out = 1 and the new HALF.
  - A rest code seen during GAP goes to REST at the end of GAP.
  - REST to TONE has no gap.
- When undefined: no GAP state, GAP_CYCLES unused, and pitch changes are seamless as described above.

Test Plan:
- Reset, then octave = 4, note = 10 (A4), CLK_HZ = 1e6 -> tone_out rises one clk after the code is sampled; high 1136 clks, low 1136 clks, repeating; active = 1.
- octave = 4, note = 1 (C4) -> half-period 1911. Switch to octave = 0 -> a 1911-clk half completes, then halves become 30576. Switch to octave = 7 -> halves become 238 at the next boundary.
- During A4, set note = 0 at an arbitrary phase -> the current half finishes, then tone_out = 0 and active = 0 at the boundary, with no runt pulse.
- Invalid codes (note = 13, or octave = 9 with note = 5) from REST -> stays REST, tone_out = 0. Glitch the code to note = 3 for 10 clks mid-A4 half, then back to note = 10 -> the period remains 1136/1136.
- Drop rstn mid-high half during A5 (half 568) -> tone_out = 0 immediately. Release rstn -> REST until the next valid sample.
- With RTTTL_TONE_GAP_EN and GAP_CYCLES = 2000: A4 -> B4 -> tone_out = 0 for exactly 2000 clks with active = 1, then B4 halves of 1012.
